mult_div_unit: RTL and testbench

//   Multi-cycle HI/LO multiply/divide unit for the MIPS datapath. It runs the

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 3
);
    logic             Start;
    logic [CTRLW-1:0] MDCtrl;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, MDCtrl, BusA, BusB,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, MDCtrl, BusA, BusB,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_FAST_MULT_EN: single-cycle combinational MULT/MULTU, divide unchanged.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 3
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_div_unit_if.slave bus
);
    localparam logic [CTRLW-1:0] OP_MULT  = 'd0;
    localparam logic [CTRLW-1:0] OP_MULTU = 'd1;
    localparam logic [CTRLW-1:0] OP_DIV   = 'd2;
    localparam logic [CTRLW-1:0] OP_DIVU  = 'd3;
    localparam logic [CTRLW-1:0] OP_MTHI  = 'd4;
    localparam logic [CTRLW-1:0] OP_MTLO  = 'd5;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_FMUL} state_t;

    state_t           state_reg;
    logic [4:0]       count_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             busy_reg, done_reg;
    logic [WIDTH-1:0] acc_reg;      // partial product high half / running remainder
    logic [WIDTH-1:0] q_reg;        // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] m_reg;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0] a_orig_reg;
    logic             is_div_reg, div_zero_reg, neg_lo_reg, neg_hi_reg;

    logic             req_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mag_prod, fixed_prod;
    logic [WIDTH-1:0] quo_fixed, rem_fixed;

    always_comb begin
        req_signed = (bus.MDCtrl == OP_MULT) || (bus.MDCtrl == OP_DIV);
        a_neg      = req_signed & bus.BusA[WIDTH-1];
        b_neg      = req_signed & bus.BusB[WIDTH-1];
        a_mag      = a_neg ? (~bus.BusA + 1'b1) : bus.BusA;
        b_mag      = b_neg ? (~bus.BusB + 1'b1) : bus.BusB;

        mul_sum    = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
        div_shift  = {acc_reg, q_reg[WIDTH-1]};
        div_diff   = div_shift - {1'b0, m_reg};

`ifdef MDU_FAST_MULT_EN
        mag_prod   = (state_reg == S_FMUL) ? ({{WIDTH{1'b0}}, m_reg} * {{WIDTH{1'b0}}, q_reg})
                                           : {acc_reg, q_reg};
`else
        mag_prod   = {acc_reg, q_reg};
`endif
        fixed_prod = neg_lo_reg ? (~mag_prod + 1'b1) : mag_prod;
        quo_fixed  = neg_lo_reg ? (~q_reg + 1'b1) : q_reg;
        rem_fixed  = neg_hi_reg ? (~acc_reg + 1'b1) : acc_reg;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            acc_reg      <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            a_orig_reg   <= '0;
            is_div_reg   <= 1'b0;
            div_zero_reg <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.Start) begin
                        case (bus.MDCtrl)
                            OP_MTHI: hi_reg <= bus.BusA;
                            OP_MTLO: lo_reg <= bus.BusA;
                            OP_MULT, OP_MULTU: begin
                                m_reg      <= a_mag;
                                q_reg      <= b_mag;
                                acc_reg    <= '0;
                                neg_lo_reg <= a_neg ^ b_neg;
                                is_div_reg <= 1'b0;
                                count_reg  <= '0;
                                busy_reg   <= 1'b1;
`ifdef MDU_FAST_MULT_EN
                                state_reg  <= S_FMUL;
`else
                                state_reg  <= S_CALC;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                m_reg        <= b_mag;
                                q_reg        <= a_mag;
                                acc_reg      <= '0;
                                neg_lo_reg   <= a_neg ^ b_neg;
                                neg_hi_reg   <= a_neg;
                                div_zero_reg <= (bus.BusB == '0);
                                a_orig_reg   <= bus.BusA;
                                is_div_reg   <= 1'b1;
                                count_reg    <= '0;
                                busy_reg     <= 1'b1;
                                state_reg    <= S_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (is_div_reg) begin
                        // Restoring step: keep the subtraction only when it did not borrow.
                        if (!div_diff[WIDTH]) begin
                            acc_reg <= div_diff[WIDTH-1:0];
                            q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_reg <= div_shift[WIDTH-1:0];
                            q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_reg <= mul_sum[WIDTH:1];
                        q_reg   <= {mul_sum[0], q_reg[WIDTH-1:1]};
                    end
                    if (count_reg == 5'd31)
                        state_reg <= S_FIN;
                    else
                        count_reg <= count_reg + 5'd1;
                end
                S_FIN: begin
                    if (is_div_reg) begin
                        if (div_zero_reg) begin
                            hi_reg <= a_orig_reg;
                            lo_reg <= '1;
                        end else begin
                            hi_reg <= rem_fixed;
                            lo_reg <= quo_fixed;
                        end
                    end else begin
                        hi_reg <= fixed_prod[2*WIDTH-1:WIDTH];
                        lo_reg <= fixed_prod[WIDTH-1:0];
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                S_FMUL: begin
                    hi_reg    <= fixed_prod[2*WIDTH-1:WIDTH];
                    lo_reg    <= fixed_prod[WIDTH-1:0];
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy = busy_reg;
    assign bus.Done = done_reg;
    assign bus.HI   = hi_reg;
    assign bus.LO   = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (honours MDU_FAST_MULT_EN for multiply latency).
module tb_mult_div_unit;
    localparam logic [2:0] C_MULT = 3'b000, C_MULTU = 3'b001, C_DIV = 3'b010,
                           C_DIVU = 3'b011, C_MTHI = 3'b100, C_MTLO = 3'b101, C_RSVD = 3'b110;
`ifdef MDU_FAST_MULT_EN
    localparam int MULT_LAT = 1;
`else
    localparam int MULT_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mult_div_unit_if #(.WIDTH(32), .CTRLW(3)) bus ();

    mult_div_unit #(.WIDTH(32), .CTRLW(3)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic launch(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        bus.Start  = 1'b1;
        bus.MDCtrl = ctrl;
        bus.BusA   = a;
        bus.BusB   = b;
        @(negedge clk);
        bus.Start  = 1'b0;
    endtask

    // Returns at the negedge on which Done is seen (or after the cycle budget).
    task automatic wait_done(input string tag, input int lat,
                             input logic [31:0] old_hi, input logic [31:0] old_lo,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        check({tag, " busy_after_e0"}, 64'(bus.Busy), 64'd1);
        check({tag, " hi_held"}, 64'(bus.HI), 64'(old_hi));
        check({tag, " lo_held"}, 64'(bus.LO), 64'(old_lo));
        while (!bus.Done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " hi"}, 64'(bus.HI), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.LO), 64'(exp_lo));
        check({tag, " busy_at_done"}, 64'(bus.Busy), 64'd0);
        $display("op %s: latency=%0d HI=%h LO=%h", tag, n, bus.HI, bus.LO);
    endtask

    task automatic check_done_drop(input string tag);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin
        int dones;
        bus.Start  = 1'b0;
        bus.MDCtrl = '0;
        bus.BusA   = '0;
        bus.BusB   = '0;

        // 1. Reset, then MTHI/MTLO
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hi", 64'(bus.HI), 64'd0);
        check("reset lo", 64'(bus.LO), 64'd0);
        check("reset busy", 64'(bus.Busy), 64'd0);
        check("reset done", 64'(bus.Done), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        launch(C_MTHI, 32'h12345678, 32'h0);
        check("mthi hi", 64'(bus.HI), 64'h12345678);
        check("mthi busy", 64'(bus.Busy), 64'd0);
        check("mthi done", 64'(bus.Done), 64'd0);
        $display("op mthi: HI=%h", bus.HI);
        launch(C_MTLO, 32'h9ABCDEF0, 32'h0);
        check("mtlo lo", 64'(bus.LO), 64'h9ABCDEF0);
        check("mtlo hi", 64'(bus.HI), 64'h12345678);
        check("mtlo busy", 64'(bus.Busy), 64'd0);
        check("mtlo done", 64'(bus.Done), 64'd0);
        $display("op mtlo: LO=%h", bus.LO);

        // Reserved code is ignored
        launch(C_RSVD, 32'hDEADBEEF, 32'h1);
        check("rsvd busy", 64'(bus.Busy), 64'd0);
        check("rsvd hi", 64'(bus.HI), 64'h12345678);
        check("rsvd lo", 64'(bus.LO), 64'h9ABCDEF0);
        @(negedge clk);
        check("rsvd done", 64'(bus.Done), 64'd0);
        $display("op reserved: HI=%h LO=%h", bus.HI, bus.LO);

        // 2. MULT -3 * 7
        launch(C_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done("mult", MULT_LAT, 32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check_done_drop("mult");

        // 3. MULTU max * max
        launch(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu", MULT_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000001);
        check_done_drop("multu");

        // 4. DIV -7 / 2, then DIVU by zero
        launch(C_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div", DIV_LAT, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_done_drop("div");
        launch(C_DIVU, 32'd100, 32'd0);
        wait_done("divu_by0", DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFFF);
        check_done_drop("divu_by0");

        // 5. Ignored Start while busy, then reset mid-op
        launch(C_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.Start  = 1'b1;
        bus.MDCtrl = C_MTHI;
        bus.BusA   = 32'h55;
        @(negedge clk);
        bus.Start  = 1'b0;
        check("busy_start hi", 64'(bus.HI), 64'd100);
        check("busy_start busy", 64'(bus.Busy), 64'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort hi", 64'(bus.HI), 64'd0);
        check("abort lo", 64'(bus.LO), 64'd0);
        check("abort busy", 64'(bus.Busy), 64'd0);
        check("abort done", 64'(bus.Done), 64'd0);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done) dones++;
        end
        check("abort no_done", 64'(dones), 64'd0);
        check("abort hi_stays", 64'(bus.HI), 64'd0);
        $display("op abort: HI=%h LO=%h dones=%0d", bus.HI, bus.LO, dones);
        launch(C_DIVU, 32'd100, 32'd7);
        wait_done("divu_rerun", DIV_LAT, 32'd0, 32'd0, 32'd2, 32'd14);
        check_done_drop("divu_rerun");

        // 6. Back-to-back: overflow divide, then MULTU on the edge after Done
        launch(C_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", DIV_LAT, 32'd2, 32'd14, 32'd0, 32'h80000000);
        launch(C_MULTU, 32'd2, 32'd3);
        wait_done("multu_b2b", MULT_LAT, 32'd0, 32'h80000000, 32'd0, 32'd6);
        check_done_drop("multu_b2b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
